// File: rtl/smu_tx_pkg.sv
// Shared types and default sizing for the SMU transmit path.
package smu_tx_pkg;

  localparam int unsigned SMU_DATA_WIDTH  = 32'd3;
  localparam int unsigned SMU_PARAM_WIDTH = 32'd3;
  localparam int unsigned SMU_BUFF_SIZE   = 32'd4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } smu_state_e;

endpackage

// File: rtl/smu_tx_fifo.sv
// Depth-counted, show-ahead circular staging FIFO; a push while full is dropped
// and flagged on ovf unless a pop frees the slot in the same cycle.
module smu_tx_fifo
  import smu_tx_pkg::*;
#(
  parameter int DATA_WIDTH = SMU_DATA_WIDTH,
  parameter int BUFF_SIZE  = SMU_BUFF_SIZE
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic                  ovf
);

  localparam int PTR_W   = $clog2(BUFF_SIZE);
  localparam int DEPTH_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem_r [BUFF_SIZE];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [DEPTH_W-1:0]    depth_r;
  logic                  full_s;
  logic                  empty_s;
  logic                  do_push_s;
  logic                  do_pop_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(BUFF_SIZE - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Occupancy flags and accepted push/pop qualification.
  always_comb begin
    full_s    = (depth_r == DEPTH_W'(BUFF_SIZE));
    empty_s   = (depth_r == {DEPTH_W{1'b0}});
    do_pop_s  = pop & ~empty_s;
    do_push_s = push & (~full_s | do_pop_s);
    ovf       = push & full_s & ~do_pop_s;
    if (empty_s) begin
      rd_data = {DATA_WIDTH{1'b0}};
    end else begin
      rd_data = mem_r[rd_ptr_r];
    end
  end

  assign full  = full_s;
  assign empty = empty_s;

  // Pointer and depth bookkeeping.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      depth_r  <= {DEPTH_W{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (do_pop_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      case ({do_push_s, do_pop_s})
        2'b10:   depth_r <= depth_r + DEPTH_W'(1);
        2'b01:   depth_r <= depth_r - DEPTH_W'(1);
        default: depth_r <= depth_r;
      endcase
    end
  end

  // Storage write; contents are qualified by depth, so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= wr_data;
  end

endmodule

// File: rtl/smu_tx.sv
// SMU transmit front end: accepts a beat-count request, then streams that many
// beats from the staging FIFO to the lanes under valid/grant handshaking.
module smu_tx
  import smu_tx_pkg::*;
#(
  parameter int DATA_WIDTH  = SMU_DATA_WIDTH,
  parameter int PARAM_WIDTH = SMU_PARAM_WIDTH,
  parameter int BUFF_SIZE   = SMU_BUFF_SIZE
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   req_valid_i,
  input  logic [PARAM_WIDTH-1:0] req_params_i,
  output logic                   req_grant_o,
  input  logic                   wr_en_i,
  input  logic [DATA_WIDTH-1:0]  wr_data_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   lane_valid_o,
  output logic [DATA_WIDTH-1:0]  lane_data_o,
  input  logic                   lane_grant_i,
  output logic                   busy_o,
  output logic                   err_o
);

  smu_state_e             state_r;
  logic [PARAM_WIDTH-1:0] cnt_r;
  logic                   err_r;
  logic                   empty_s;
  logic                   ovf_s;
  logic                   busy_s;
  logic                   lane_valid_s;
  logic                   xfer_s;

  smu_tx_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUFF_SIZE  (BUFF_SIZE)
  ) u_fifo (
    .clk     (clk),
    .arst_n  (arst_n),
    .push    (wr_en_i),
    .wr_data (wr_data_i),
    .pop     (xfer_s),
    .rd_data (lane_data_o),
    .full    (full_o),
    .empty   (empty_s),
    .ovf     (ovf_s)
  );

  // Lane handshake derived from registered state only, never from the grant.
  always_comb begin
    busy_s       = (state_r == SEND);
    lane_valid_s = busy_s & ~empty_s;
    xfer_s       = lane_valid_s & lane_grant_i;
  end

  assign req_grant_o  = (state_r == IDLE);
  assign busy_o       = busy_s;
  assign lane_valid_o = lane_valid_s;
  assign empty_o      = empty_s;
  assign err_o        = err_r;

  // Request FSM, remaining-beat counter and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_r <= IDLE;
      cnt_r   <= {PARAM_WIDTH{1'b0}};
      err_r   <= 1'b0;
    end else begin
      if (ovf_s) err_r <= 1'b1;
      case (state_r)
        IDLE: begin
          if (req_valid_i && (req_params_i != {PARAM_WIDTH{1'b0}})) begin
            cnt_r   <= req_params_i;
            state_r <= SEND;
          end
        end
        SEND: begin
          if (xfer_s && (cnt_r != {PARAM_WIDTH{1'b0}})) begin
            cnt_r <= cnt_r - PARAM_WIDTH'(1);
            if (cnt_r == PARAM_WIDTH'(1)) state_r <= IDLE;
          end else if (cnt_r == {PARAM_WIDTH{1'b0}}) begin
            // Unreachable in normal operation; recovers rather than stalling.
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= {PARAM_WIDTH{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: doc/smu_tx.md
SMU_TX -- requirements
Module: smu_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 3, meaning lane data width in bits.
REQ-002 SHALL have parameter PARAM_WIDTH, default 3, meaning request beat-count width in bits.
REQ-003 SHALL have parameter BUFF_SIZE, default 4, meaning staging FIFO depth in entries (power of two, at least 2).
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-005 SHALL have port arst_n, input, 1 bit, reset; it is synchronous and active-low.
REQ-006 SHALL have port req_valid_i, input, 1 bit, send request offered.
REQ-007 SHALL have port req_params_i, input, PARAM_WIDTH bits, number of beats to send.
REQ-008 SHALL have port req_grant_o, output, 1 bit, request accepted when it is high together with req_valid_i.
REQ-009 SHALL have port wr_en_i, input, 1 bit, push into the staging FIFO.
REQ-010 SHALL have port wr_data_i, input, DATA_WIDTH bits, push data.
REQ-011 SHALL have ports full_o and empty_o, outputs, 1 bit each, staging FIFO state.
REQ-012 SHALL have port lane_valid_o, output, 1 bit, beat offered to the lanes.
REQ-013 SHALL have port lane_data_o, output, DATA_WIDTH bits, beat data.
REQ-014 SHALL have port lane_grant_i, input, 1 bit, lanes accept the beat.
REQ-015 SHALL have port busy_o, output, 1 bit, high while in SEND.
REQ-016 SHALL have port err_o, output, 1 bit, sticky flag for a push while full.

Function
REQ-017 SHALL implement an FSM with states IDLE and SEND, with all state held in registers.
REQ-018 IDLE SHALL drive req_grant_o=1; SEND SHALL drive req_grant_o=0.
REQ-019 In IDLE, a handshake with req_params_i=0 SHALL be consumed, leaving the FSM in IDLE with no beats sent.
REQ-020 In IDLE, a handshake with req_params_i=N>0 SHALL load the remaining-beat counter with N and enter SEND on the next cycle.
REQ-021 lane_valid_o SHALL equal (state==SEND) AND NOT empty_o, combinationally.
REQ-022 lane_data_o SHALL always show the FIFO head (show-ahead); lane_data_o SHALL be zero when the FIFO is empty.
REQ-023 A beat SHALL transfer only on a cycle where lane_valid_o and lane_grant_i are both high; that cycle pops the FIFO and decrements the counter.
REQ-024 A transfer with counter==1 SHALL return the FSM to IDLE on the next cycle, so req_grant_o is high one cycle after the last beat.
REQ-025 lane_valid_o SHALL NOT depend on lane_grant_i; once high, it SHALL stay high with stable data until a transfer occurs.
REQ-026 A push SHALL write wr_data_i when NOT full_o; a push when full_o SHALL be dropped and SHALL set err_o, which stays set until reset.
REQ-027 A simultaneous push and pop SHALL be legal when full, leave the occupancy unchanged, and SHALL NOT set err_o.
REQ-028 Pushes SHALL be accepted in any FSM state.
REQ-029 A push into an empty FIFO SHALL NOT be visible on lane_valid_o before the next cycle.
REQ-030 FIFO pointers SHALL wrap from BUFF_SIZE-1 to 0.
REQ-031 Occupancy SHALL be a depth counter of width log2(BUFF_SIZE)+1; full_o SHALL be depth==BUFF_SIZE and empty_o SHALL be depth==0.
REQ-032 Counter decrements SHALL never underflow, and the counter SHALL NOT change outside of transfers.

Reset
REQ-033 When arst_n=0 at a clock edge, the block SHALL set state=IDLE, depth=0, pointers=0, counter=0, err_o=0.
REQ-034 During and after reset, outputs SHALL be req_grant_o=1 (IDLE), lane_valid_o=0, lane_data_o=0, full_o=0, empty_o=1, busy_o=0.
REQ-035 Reset asserted mid-SEND SHALL abort the transfer and discard the FIFO contents; no beat SHALL be emitted on the cycle after reset.
REQ-036 FIFO storage SHALL need no reset.

Structure
REQ-037 A shared package SHALL hold the FSM state enum type and the default DATA_WIDTH, PARAM_WIDTH and BUFF_SIZE constants.
REQ-038 The staging storage SHALL be one sub-module, smu_tx_fifo: a depth-counted, show-ahead circular FIFO with full, empty and overflow outputs.
REQ-039 The FSM and counter SHALL live in smu_tx.

Verification
REQ-040 Reset, push 1,2; request N=2 with lane_grant_i held high -> req_grant_o=0 for 2 cycles; lane_data_o shows 1 then 2; req_grant_o returns to 1; empty_o=1.
REQ-041 Request N=3 with the FIFO empty, then push 5,6,7 one per cycle -> each beat is emitted the cycle after its push; the FSM returns to IDLE after 7.
REQ-042 Push 1..4 (full_o=1), then push 9 -> err_o=1 and stays 1; the FIFO still contains 1,2,3,4.
REQ-043 With the FIFO full and SEND active, push 8 and grant in the same cycle -> 1 is popped, 8 is enqueued, depth stays 4, err_o=0.
REQ-044 Request N=0 -> req_grant_o stays 1, lane_valid_o never asserts, and the counter stays 0.
REQ-045 Request N=3; after 1 beat, hold lane_grant_i=0 for 3 cycles -> lane_data_o is stable at beat 2; then assert arst_n=0 -> outputs match REQ-034 on the next cycle.
